// File: rtl/qsys_m1_arbiter.sv
// qsys_m1_arbiter: two-port round-robin arbiter sharing one Avalon-MM master.
// Grants whole bursts, tracks outstanding pipelined reads and routes
// readdatavalid back to the owning port. Ownership only changes once every
// read issued under the current grant has returned.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; both ports stalled; pick the next owner
// GRANT | owner's commands pass straight through to the master
// DRAIN | grant released, waiting for outstanding reads to return
module qsys_m1_arbiter #(
  parameter int MAX_PENDING = 4,
  parameter int BURST_LIMIT = 8
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,

  input  logic [31:0] avs_S0_address,
  input  logic [31:0] avs_S0_writedata,
  input  logic [3:0]  avs_S0_byteenable,
  input  logic        avs_S0_write,
  input  logic        avs_S0_read,
  output logic [31:0] avs_S0_readdata,
  output logic        avs_S0_readdatavalid,
  output logic        avs_S0_waitrequest,

  input  logic [31:0] avs_S1_address,
  input  logic [31:0] avs_S1_writedata,
  input  logic [3:0]  avs_S1_byteenable,
  input  logic        avs_S1_write,
  input  logic        avs_S1_read,
  output logic [31:0] avs_S1_readdata,
  output logic        avs_S1_readdatavalid,
  output logic        avs_S1_waitrequest,

  output logic [31:0] avm_M1_address,
  output logic [31:0] avm_M1_writedata,
  output logic [3:0]  avm_M1_byteenable,
  output logic        avm_M1_write,
  output logic        avm_M1_read,
  output logic        avm_M1_begintransfer,
  input  logic [31:0] avm_M1_readdata,
  input  logic        avm_M1_readdatavalid,
  input  logic        avm_M1_waitrequest
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int BW = $clog2(BURST_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic          busy, busy_nxt;
  logic [PW-1:0] pend, pend_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;

  logic req0, req1;
  logic own_read, own_write, own_cmd, other_req;
  logic in_grant, active, stall, accept, acc_read, rdv_eff, limit_hit;
  logic win;

  assign req0      = avs_S0_read | avs_S0_write;
  assign req1      = avs_S1_read | avs_S1_write;
  assign own_read  = owner ? avs_S1_read  : avs_S0_read;
  assign own_write = owner ? avs_S1_write : avs_S0_write;
  assign own_cmd   = own_read | own_write;
  assign other_req = owner ? req0 : req1;

  assign in_grant  = (state == GRANT);
  assign active    = (state != IDLE);
  assign stall     = (pend == PW'(MAX_PENDING));
  assign accept    = in_grant & own_cmd & ~avm_M1_waitrequest & ~stall;
  assign acc_read  = accept & own_read;
  // A stray readdatavalid with nothing outstanding (e.g. after reset) is dropped.
  assign rdv_eff   = avm_M1_readdatavalid & (pend != '0);
  // The burst limit only ends a grant when the other port is actually waiting.
  assign limit_hit = accept & other_req & (bcnt >= BW'(BURST_LIMIT - 1));

  assign avs_S0_readdata = avm_M1_readdata;
  assign avs_S1_readdata = avm_M1_readdata;

  assign avs_S0_readdatavalid = rdv_eff & active & ~owner;
  assign avs_S1_readdatavalid = rdv_eff & active &  owner;

  assign avs_S0_waitrequest = (in_grant & ~owner) ? (avm_M1_waitrequest | stall) : 1'b1;
  assign avs_S1_waitrequest = (in_grant &  owner) ? (avm_M1_waitrequest | stall) : 1'b1;

  // Master side: unregistered 2:1 mux of the owner, quiet outside GRANT.
  always_comb begin
    avm_M1_address       = '0;
    avm_M1_writedata     = '0;
    avm_M1_byteenable    = '0;
    avm_M1_read          = 1'b0;
    avm_M1_write         = 1'b0;
    avm_M1_begintransfer = 1'b0;
    if (in_grant) begin
      avm_M1_address       = owner ? avs_S1_address    : avs_S0_address;
      avm_M1_writedata     = owner ? avs_S1_writedata  : avs_S0_writedata;
      avm_M1_byteenable    = owner ? avs_S1_byteenable : avs_S0_byteenable;
      avm_M1_read          = own_read  & ~stall;
      avm_M1_write         = own_write & ~stall;
      avm_M1_begintransfer = own_cmd & ~stall & ~busy;
    end
  end

  // Outstanding-read count: simultaneous issue and return cancel out.
  always_comb begin
    pend_nxt = pend;
    case ({acc_read, rdv_eff})
      2'b10:   pend_nxt = pend + PW'(1);
      2'b01:   pend_nxt = pend - PW'(1);
      default: pend_nxt = pend;
    endcase
  end

  // Next-state logic: arbitration, burst counting and grant release.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    busy_nxt  = in_grant & own_cmd & ~stall & avm_M1_waitrequest;
    win       = (req0 & req1) ? ~last : req1;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          owner_nxt = win;
          last_nxt  = win;
          bcnt_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (accept && (bcnt != BW'(BURST_LIMIT))) bcnt_nxt = bcnt + BW'(1);
        if (!own_cmd || limit_hit) state_nxt = (pend_nxt != '0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (pend_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      pend  <= '0;
      bcnt  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      pend  <= pend_nxt;
      bcnt  <= bcnt_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_qsys_m1_arbiter.sv
// Directed bench for qsys_m1_arbiter with default parameters
// (MAX_PENDING = 4, BURST_LIMIT = 8).
module tb_qsys_m1_arbiter;

  logic        csi_MCLK_clk = 1'b0;
  logic        rsi_MRST_reset;
  logic [31:0] avs_S0_address, avs_S0_writedata, avs_S1_address, avs_S1_writedata;
  logic [3:0]  avs_S0_byteenable, avs_S1_byteenable;
  logic        avs_S0_write, avs_S0_read, avs_S1_write, avs_S1_read;
  logic [31:0] avs_S0_readdata, avs_S1_readdata;
  logic        avs_S0_readdatavalid, avs_S0_waitrequest;
  logic        avs_S1_readdatavalid, avs_S1_waitrequest;
  logic [31:0] avm_M1_address, avm_M1_writedata;
  logic [3:0]  avm_M1_byteenable;
  logic        avm_M1_write, avm_M1_read, avm_M1_begintransfer;
  logic [31:0] avm_M1_readdata;
  logic        avm_M1_readdatavalid, avm_M1_waitrequest;

  int vecs = 0;
  int errs = 0;

  always #5 csi_MCLK_clk = ~csi_MCLK_clk;

  qsys_m1_arbiter dut (
    .csi_MCLK_clk         (csi_MCLK_clk),
    .rsi_MRST_reset       (rsi_MRST_reset),
    .avs_S0_address       (avs_S0_address),
    .avs_S0_writedata     (avs_S0_writedata),
    .avs_S0_byteenable    (avs_S0_byteenable),
    .avs_S0_write         (avs_S0_write),
    .avs_S0_read          (avs_S0_read),
    .avs_S0_readdata      (avs_S0_readdata),
    .avs_S0_readdatavalid (avs_S0_readdatavalid),
    .avs_S0_waitrequest   (avs_S0_waitrequest),
    .avs_S1_address       (avs_S1_address),
    .avs_S1_writedata     (avs_S1_writedata),
    .avs_S1_byteenable    (avs_S1_byteenable),
    .avs_S1_write         (avs_S1_write),
    .avs_S1_read          (avs_S1_read),
    .avs_S1_readdata      (avs_S1_readdata),
    .avs_S1_readdatavalid (avs_S1_readdatavalid),
    .avs_S1_waitrequest   (avs_S1_waitrequest),
    .avm_M1_address       (avm_M1_address),
    .avm_M1_writedata     (avm_M1_writedata),
    .avm_M1_byteenable    (avm_M1_byteenable),
    .avm_M1_write         (avm_M1_write),
    .avm_M1_read          (avm_M1_read),
    .avm_M1_begintransfer (avm_M1_begintransfer),
    .avm_M1_readdata      (avm_M1_readdata),
    .avm_M1_readdatavalid (avm_M1_readdatavalid),
    .avm_M1_waitrequest   (avm_M1_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge csi_MCLK_clk);
    #1;
  endtask

  // Outputs are sampled 3 time units after the rising edge.
  task automatic settle();
    #2;
  endtask

  logic [31:0] wlog[$];
  logic [31:0] wexp[$];
  int          due[$];
  int          s0_idx, s1_idx, r_idx;
  logic        s1_gap, acc0, acc1;
  logic [15:0] rd_mask, wr_mask, s0v_mask, w1_mask;

  initial begin
    rsi_MRST_reset       = 1'b1;
    avs_S0_address       = 32'h1234_5678;
    avs_S0_writedata     = 32'h0;
    avs_S0_byteenable    = 4'hF;
    avs_S0_write         = 1'b1;
    avs_S0_read          = 1'b0;
    avs_S1_address       = 32'h0;
    avs_S1_writedata     = 32'h0;
    avs_S1_byteenable    = 4'hF;
    avs_S1_write         = 1'b0;
    avs_S1_read          = 1'b0;
    avm_M1_readdata      = 32'h0;
    avm_M1_readdatavalid = 1'b0;
    avm_M1_waitrequest   = 1'b0;

    // reset state
    cyc(); cyc(); settle();
    chk("rst_read",  avm_M1_read, 0);
    chk("rst_write", avm_M1_write, 0);
    chk("rst_begin", avm_M1_begintransfer, 0);
    chk("rst_addr",  avm_M1_address, 0);
    chk("rst_wait0", avs_S0_waitrequest, 1);
    chk("rst_wait1", avs_S1_waitrequest, 1);
    chk("rst_rdv0",  avs_S0_readdatavalid, 0);

    // single S0 read, slave latency 3, then S1 write handover
    cyc();
    rsi_MRST_reset = 1'b0;
    avs_S0_write   = 1'b0;
    avs_S0_read    = 1'b1;
    avs_S0_address = 32'h1000_0040;
    settle();
    chk("rd_idle_wait0", avs_S0_waitrequest, 1);
    chk("rd_idle_read",  avm_M1_read, 0);
    cyc(); settle();
    chk("rd_read",  avm_M1_read, 1);
    chk("rd_addr",  avm_M1_address, 32'h1000_0040);
    chk("rd_begin", avm_M1_begintransfer, 1);
    chk("rd_wait0", avs_S0_waitrequest, 0);
    chk("rd_wait1", avs_S1_waitrequest, 1);
    cyc(); avs_S0_read = 1'b0; settle();
    chk("rd_exit_read",  avm_M1_read, 0);
    chk("rd_exit_begin", avm_M1_begintransfer, 0);
    cyc(); avs_S1_write = 1'b1; avs_S1_address = 32'h2000_0000; settle();
    chk("drain_write", avm_M1_write, 0);
    chk("drain_wait0", avs_S0_waitrequest, 1);
    chk("drain_wait1", avs_S1_waitrequest, 1);
    chk("drain_rdv0",  avs_S0_readdatavalid, 0);
    cyc(); avm_M1_readdatavalid = 1'b1; avm_M1_readdata = 32'hDEAD_BEEF; settle();
    chk("rd_rdv0",  avs_S0_readdatavalid, 1);
    chk("rd_data0", avs_S0_readdata, 32'hDEAD_BEEF);
    chk("rd_rdv1",  avs_S1_readdatavalid, 0);
    chk("rd_begin_drain", avm_M1_begintransfer, 0);
    cyc(); avm_M1_readdatavalid = 1'b0; settle();
    chk("ho_idle_rdv0",  avs_S0_readdatavalid, 0);
    chk("ho_idle_wait1", avs_S1_waitrequest, 1);
    chk("ho_idle_write", avm_M1_write, 0);
    cyc(); settle();
    chk("ho_write", avm_M1_write, 1);
    chk("ho_addr",  avm_M1_address, 32'h2000_0000);
    chk("ho_wait1", avs_S1_waitrequest, 0);
    chk("ho_begin", avm_M1_begintransfer, 1);
    cyc(); avs_S1_write = 1'b0;
    cyc();

    // simultaneous writes: S0 first, waitrequest holds begintransfer off
    avs_S0_write = 1'b1; avs_S0_address = 32'h100; avs_S0_writedata = 32'hA0; avs_S0_byteenable = 4'h3;
    avs_S1_write = 1'b1; avs_S1_address = 32'h200; avs_S1_writedata = 32'hB0; avs_S1_byteenable = 4'hC;
    settle();
    chk("tie_idle_wait0", avs_S0_waitrequest, 1);
    chk("tie_idle_wait1", avs_S1_waitrequest, 1);
    cyc(); avm_M1_waitrequest = 1'b1; settle();
    chk("tie_write", avm_M1_write, 1);
    chk("tie_addr",  avm_M1_address, 32'h100);
    chk("tie_wdata", avm_M1_writedata, 32'hA0);
    chk("tie_be",    avm_M1_byteenable, 4'h3);
    chk("tie_begin", avm_M1_begintransfer, 1);
    chk("tie_wait0_stalled", avs_S0_waitrequest, 1);
    chk("tie_wait1", avs_S1_waitrequest, 1);
    cyc(); avm_M1_waitrequest = 1'b0; settle();
    chk("busy_begin", avm_M1_begintransfer, 0);
    chk("busy_wait0", avs_S0_waitrequest, 0);
    chk("busy_wait1", avs_S1_waitrequest, 1);
    cyc(); avs_S0_address = 32'h104; avs_S0_writedata = 32'hA1; settle();
    chk("b2b_begin", avm_M1_begintransfer, 1);
    chk("b2b_addr",  avm_M1_address, 32'h104);
    cyc(); avs_S0_write = 1'b0; settle();
    chk("tie_exit_write", avm_M1_write, 0);
    chk("tie_exit_wait1", avs_S1_waitrequest, 1);
    cyc(); settle();
    chk("tie_idle2_wait1", avs_S1_waitrequest, 1);
    cyc(); settle();
    chk("s1_write", avm_M1_write, 1);
    chk("s1_addr",  avm_M1_address, 32'h200);
    chk("s1_wdata", avm_M1_writedata, 32'hB0);
    chk("s1_be",    avm_M1_byteenable, 4'hC);
    chk("s1_wait1", avs_S1_waitrequest, 0);
    chk("s1_wait0", avs_S0_waitrequest, 1);
    cyc(); avs_S1_write = 1'b0;
    cyc();

    // burst limit: S0 streams 20 writes, S1 has 2 writes with a gap after each
    for (int i = 0; i < 8; i++)  wexp.push_back(32'h1000 + 32'(4 * i));
    wexp.push_back(32'h2000);
    for (int i = 8; i < 16; i++) wexp.push_back(32'h1000 + 32'(4 * i));
    wexp.push_back(32'h2004);
    for (int i = 16; i < 20; i++) wexp.push_back(32'h1000 + 32'(4 * i));
    s0_idx = 0; s1_idx = 0; s1_gap = 1'b0;
    for (int c = 0; c < 200 && !(s0_idx == 20 && s1_idx == 2); c++) begin
      avs_S0_write   = (s0_idx < 20);
      avs_S0_address = 32'h1000 + 32'(4 * s0_idx);
      avs_S1_write   = (s1_idx < 2) && !s1_gap;
      avs_S1_address = 32'h2000 + 32'(4 * s1_idx);
      settle();
      if (avm_M1_write && !avm_M1_waitrequest) wlog.push_back(avm_M1_address);
      acc0 = avs_S0_write & ~avs_S0_waitrequest;
      acc1 = avs_S1_write & ~avs_S1_waitrequest;
      cyc();
      s1_gap = acc1;
      if (acc0) s0_idx++;
      if (acc1) s1_idx++;
    end
    avs_S0_write = 1'b0; avs_S1_write = 1'b0;
    chk("burst_done", {31'b0, (s0_idx == 20 && s1_idx == 2)}, 1);
    chk("burst_count", wlog.size(), 22);
    for (int i = 0; i < 22 && i < wlog.size(); i++)
      chk($sformatf("burst_order_%0d", i), wlog[i], wexp[i]);
    cyc();

    // pipelined reads with MAX_PENDING stall, slave latency 5, S1 waiting
    rd_mask  = 16'h019E;
    wr_mask  = 16'h8000;
    s0v_mask = 16'h33C0;
    w1_mask  = 16'h7FFF;
    r_idx = 0;
    avs_S1_address = 32'h4000;
    for (int c = 0; c < 16; c++) begin
      avs_S0_read          = (r_idx < 6);
      avs_S0_address       = 32'h3000 + 32'(4 * r_idx);
      avs_S1_write         = (c >= 1);
      avm_M1_readdatavalid = (due.size() > 0) && (due[0] == c);
      avm_M1_readdata      = 32'h5000 + 32'(c);
      settle();
      chk($sformatf("pipe_read_c%0d", c),  avm_M1_read, rd_mask[c]);
      chk($sformatf("pipe_write_c%0d", c), avm_M1_write, wr_mask[c]);
      chk($sformatf("pipe_rdv0_c%0d", c),  avs_S0_readdatavalid, s0v_mask[c]);
      chk($sformatf("pipe_rdv1_c%0d", c),  avs_S1_readdatavalid, 0);
      chk($sformatf("pipe_wait1_c%0d", c), avs_S1_waitrequest, w1_mask[c]);
      if (avs_S0_read && !avs_S0_waitrequest) begin
        due.push_back(c + 5);
        r_idx++;
      end
      if (avm_M1_readdatavalid) void'(due.pop_front());
      cyc();
    end
    chk("pipe_all_returned", due.size(), 0);
    avs_S1_write = 1'b0; avm_M1_readdatavalid = 1'b0; avs_S0_read = 1'b0;
    cyc();

    // read accepted in the same cycle as a return with pend = 2
    avs_S0_read = 1'b1; avs_S0_address = 32'h6000;
    cyc(); settle();
    chk("same_r0_read", avm_M1_read, 1);
    cyc(); avs_S0_address = 32'h6004;
    cyc(); avs_S0_address = 32'h6008; avm_M1_readdatavalid = 1'b1; settle();
    chk("same_r2_read", avm_M1_read, 1);
    chk("same_rdv0",    avs_S0_readdatavalid, 1);
    cyc(); avs_S0_read = 1'b0; avm_M1_readdatavalid = 1'b0; settle();
    chk("same_exit_rdv0", avs_S0_readdatavalid, 0);
    cyc(); avm_M1_readdatavalid = 1'b1; settle();
    chk("same_ret1_rdv0", avs_S0_readdatavalid, 1);
    cyc(); settle();
    chk("same_ret2_rdv0", avs_S0_readdatavalid, 1);
    cyc(); settle();
    chk("same_stray_rdv0", avs_S0_readdatavalid, 0);
    cyc(); avm_M1_readdatavalid = 1'b0;

    // reset in DRAIN with three reads outstanding
    avs_S0_read = 1'b1; avs_S0_address = 32'h7000;
    cyc(); cyc(); cyc(); cyc();
    avs_S0_read = 1'b0;
    cyc(); avs_S1_write = 1'b1; rsi_MRST_reset = 1'b1; settle();
    chk("rdrain_write", avm_M1_write, 0);
    chk("rdrain_wait0", avs_S0_waitrequest, 1);
    chk("rdrain_wait1", avs_S1_waitrequest, 1);
    cyc(); rsi_MRST_reset = 1'b0; avs_S1_write = 1'b0; avm_M1_readdatavalid = 1'b1; settle();
    chk("post_rst_read",  avm_M1_read, 0);
    chk("post_rst_write", avm_M1_write, 0);
    chk("post_rst_begin", avm_M1_begintransfer, 0);
    chk("post_rst_addr",  avm_M1_address, 0);
    chk("post_rst_wdata", avm_M1_writedata, 0);
    chk("post_rst_be",    avm_M1_byteenable, 0);
    chk("post_rst_wait0", avs_S0_waitrequest, 1);
    chk("post_rst_wait1", avs_S1_waitrequest, 1);
    chk("late_rdv0_a",    avs_S0_readdatavalid, 0);
    chk("late_rdv1_a",    avs_S1_readdatavalid, 0);
    cyc(); settle();
    chk("late_rdv0_b", avs_S0_readdatavalid, 0);
    cyc(); settle();
    chk("late_rdv0_c", avs_S0_readdatavalid, 0);
    chk("late_rdv1_c", avs_S1_readdatavalid, 0);
    cyc();
    avm_M1_readdatavalid = 1'b0;
    avs_S0_write = 1'b1; avs_S0_address = 32'h8000;
    avs_S1_write = 1'b1; avs_S1_address = 32'h9000;
    cyc(); settle();
    chk("rst_tie_wait0", avs_S0_waitrequest, 0);
    chk("rst_tie_wait1", avs_S1_waitrequest, 1);
    chk("rst_tie_addr",  avm_M1_address, 32'h8000);
    avs_S0_write = 1'b0; avs_S1_write = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
